// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage bus between the PC controller and its neighbours: redirect/stall
// controls in, instruction-memory address/read and fetch tags out.
interface fetch_pc_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              call_en;
  logic              ret_en;
  logic              halt;
  logic              resume;
  logic [ADDR_W-1:0] Address;
  logic              instRead;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_valid;
  logic              pc_wrap;
  logic              ras_err;

  modport master (
    output stall, br_taken, br_target, call_en, ret_en, halt, resume,
    input  Address, instRead, fetch_pc, fetch_valid, pc_wrap, ras_err
  );

  modport slave (
    input  stall, br_taken, br_target, call_en, ret_en, halt, resume,
    output Address, instRead, fetch_pc, fetch_valid, pc_wrap, ras_err
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// PC / fetch control ahead of the instruction memory, tagging each fetched word.
// Optional return-address stack enabled by defining FETCH_RAS_EN.
module fetch_pc_ctrl #(
  parameter int unsigned          ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter int unsigned          RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            Reset,
  fetch_pc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              pc_wrap_q, pc_wrap_d;
  logic              redirect_br;

  assign pc_inc = pc_q + ADDR_W'(1);

`ifdef FETCH_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_sp_q, ras_sp_inc, ras_sp_dec;
  logic [CNT_W-1:0]  ras_cnt_q;
  logic              ras_empty;
  logic              ras_push, ras_pop;
  logic              ras_err_q, ras_err_d;

  // sp points at the next free slot; full pushes wrap and overwrite the oldest.
  assign ras_sp_inc = (ras_sp_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_sp_q + PTR_W'(1);
  assign ras_sp_dec = (ras_sp_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_sp_q - PTR_W'(1);
  assign ras_empty  = (ras_cnt_q == '0);
  assign redirect_br = bus.br_taken;
`else
  assign redirect_br = bus.br_taken | bus.call_en;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    pc_wrap_d     = pc_wrap_q;
`ifdef FETCH_RAS_EN
    ras_push      = 1'b0;
    ras_pop       = 1'b0;
    ras_err_d     = ras_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        state_d       = RUN;
        fetch_valid_d = 1'b0;
      end
      RUN: begin
        if (redirect_br) begin
          pc_d          = bus.br_target;
          fetch_valid_d = 1'b0;
`ifdef FETCH_RAS_EN
        end else if (bus.ret_en) begin
          ras_pop       = 1'b1;
          fetch_valid_d = 1'b0;
          if (ras_empty) begin
            pc_d      = RESET_PC;
            ras_err_d = 1'b1;
          end else begin
            pc_d = ras_q[ras_sp_dec];
          end
        end else if (bus.call_en) begin
          ras_push      = 1'b1;
          pc_d          = bus.br_target;
          fetch_valid_d = 1'b0;
`endif
        end else if (bus.halt) begin
          state_d       = HALT;
          fetch_valid_d = 1'b0;
        end else if (!bus.stall) begin
          fetch_pc_d    = pc_q;
          fetch_valid_d = 1'b1;
          pc_d          = pc_inc;
          if (pc_q == '1) pc_wrap_d = 1'b1;
        end
      end
      HALT: begin
        if (bus.br_taken) begin
          pc_d    = bus.br_target;
          state_d = RUN;
        end else if (bus.resume) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
      pc_wrap_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      pc_wrap_q     <= pc_wrap_d;
    end
  end

`ifdef FETCH_RAS_EN
  always_ff @(posedge clk) begin
    if (Reset) begin
      ras_sp_q  <= '0;
      ras_cnt_q <= '0;
      ras_err_q <= 1'b0;
    end else begin
      ras_err_q <= ras_err_d;
      if (ras_push) begin
        ras_sp_q <= ras_sp_inc;
        if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + CNT_W'(1);
      end else if (ras_pop && !ras_empty) begin
        ras_sp_q  <= ras_sp_dec;
        ras_cnt_q <= ras_cnt_q - CNT_W'(1);
      end
    end
  end

  // Entries need no reset: the occupancy count alone defines what is live.
  always_ff @(posedge clk) begin
    if (!Reset && ras_push) ras_q[ras_sp_q] <= pc_inc;
  end

  assign bus.ras_err = ras_err_q;
`else
  assign bus.ras_err = 1'b0;
`endif

  assign bus.Address     = pc_q;
  assign bus.instRead    = !Reset && (state_q == RUN) && !bus.stall;
  assign bus.fetch_pc    = fetch_pc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.pc_wrap     = pc_wrap_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl; return-stack scenarios follow FETCH_RAS_EN.
module tb_fetch_pc_ctrl;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl_if #(.ADDR_W(8)) bus ();

  fetch_pc_ctrl #(.ADDR_W(8), .RESET_PC(8'h00), .RAS_DEPTH(4)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [7:0] tgt);
    bus.br_taken  = 1'b1;
    bus.br_target = tgt;
    tick();
    bus.br_taken  = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #1;
    checks++; if (bus.instRead !== 1'b0) begin errors++; $display("FAIL rst_inst_async: got %b expected 0", bus.instRead); end
    tick();
    tick();
    checks++; if (bus.Address !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h expected 00", bus.Address); end
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.fetch_valid); end
    checks++; if (bus.fetch_pc !== 8'h00) begin errors++; $display("FAIL rst_fpc: got %h expected 00", bus.fetch_pc); end
    checks++; if (bus.pc_wrap !== 1'b0) begin errors++; $display("FAIL rst_wrap: got %b expected 0", bus.pc_wrap); end
    checks++; if (bus.ras_err !== 1'b0) begin errors++; $display("FAIL rst_raserr: got %b expected 0", bus.ras_err); end
    checks++; if (bus.instRead !== 1'b0) begin errors++; $display("FAIL rst_inst: got %b expected 0", bus.instRead); end
    Reset = 1'b0;
    #1;
    checks++; if (bus.instRead !== 1'b0) begin errors++; $display("FAIL idle_inst: got %b expected 0", bus.instRead); end
    tick();
    checks++; if (bus.instRead !== 1'b1) begin errors++; $display("FAIL run_inst: got %b expected 1", bus.instRead); end
    checks++; if (bus.Address !== 8'h00) begin errors++; $display("FAIL first_addr: got %h expected 00", bus.Address); end
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL first_valid0: got %b expected 0", bus.fetch_valid); end
    tick();
    checks++; if (bus.fetch_pc !== 8'h00 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL first_fetch: got %h/%b expected 00/1", bus.fetch_pc, bus.fetch_valid); end
    checks++; if (bus.Address !== 8'h01) begin errors++; $display("FAIL addr_01: got %h expected 01", bus.Address); end
    tick();
    checks++; if (bus.Address !== 8'h02 || bus.fetch_pc !== 8'h01) begin errors++; $display("FAIL addr_02: got %h/%h expected 02/01", bus.Address, bus.fetch_pc); end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 16 && bus.Address !== 8'h05; i++) tick();
    checks++; if (bus.Address !== 8'h05) begin errors++; $display("FAIL reach_05: got %h expected 05", bus.Address); end
    jump(8'h40);
    checks++; if (bus.fetch_valid !== 1'b0 || bus.Address !== 8'h40) begin errors++; $display("FAIL br_bubble: got %h/%b expected 40/0", bus.Address, bus.fetch_valid); end
    tick();
    checks++; if (bus.fetch_pc !== 8'h40 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL br_target: got %h/%b expected 40/1", bus.fetch_pc, bus.fetch_valid); end
    checks++; if (bus.Address !== 8'h41) begin errors++; $display("FAIL br_next: got %h expected 41", bus.Address); end
  endtask

  task automatic test_stall_branch();
    jump(8'h0F);
    tick();
    checks++; if (bus.Address !== 8'h10 || bus.fetch_pc !== 8'h0F) begin errors++; $display("FAIL pre_stall: got %h/%h expected 10/0f", bus.Address, bus.fetch_pc); end
    bus.stall = 1'b1;
    #1;
    checks++; if (bus.instRead !== 1'b0) begin errors++; $display("FAIL stall_inst: got %b expected 0", bus.instRead); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.Address !== 8'h10 || bus.fetch_pc !== 8'h0F || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got %h/%h/%b expected 10/0f/1", i, bus.Address, bus.fetch_pc, bus.fetch_valid); end
    end
    jump(8'h20);
    checks++; if (bus.Address !== 8'h20 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_br: got %h/%b expected 20/0", bus.Address, bus.fetch_valid); end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.fetch_pc !== 8'h20 || bus.fetch_valid !== 1'b1 || bus.Address !== 8'h21) begin errors++; $display("FAIL stall_br_fetch: got %h/%b/%h expected 20/1/21", bus.fetch_pc, bus.fetch_valid, bus.Address); end
  endtask

  task automatic test_wrap();
    jump(8'hFE);
    checks++; if (bus.Address !== 8'hFE || bus.pc_wrap !== 1'b0) begin errors++; $display("FAIL wrap_fe: got %h/%b expected fe/0", bus.Address, bus.pc_wrap); end
    tick();
    checks++; if (bus.Address !== 8'hFF || bus.pc_wrap !== 1'b0) begin errors++; $display("FAIL wrap_ff: got %h/%b expected ff/0", bus.Address, bus.pc_wrap); end
    tick();
    checks++; if (bus.Address !== 8'h00 || bus.pc_wrap !== 1'b1 || bus.fetch_pc !== 8'hFF) begin errors++; $display("FAIL wrap_00: got %h/%b/%h expected 00/1/ff", bus.Address, bus.pc_wrap, bus.fetch_pc); end
    tick();
    checks++; if (bus.pc_wrap !== 1'b1) begin errors++; $display("FAIL wrap_sticky: got %b expected 1", bus.pc_wrap); end
    test_reset();
    jump(8'hFF);
    jump(8'h00);
    checks++; if (bus.Address !== 8'h00 || bus.pc_wrap !== 1'b0) begin errors++; $display("FAIL redirect_nowrap: got %h/%b expected 00/0", bus.Address, bus.pc_wrap); end
  endtask

  task automatic test_halt();
    jump(8'h30);
    bus.halt = 1'b1;
    tick();
    checks++; if (bus.Address !== 8'h30 || bus.instRead !== 1'b0 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_enter: got %h/%b/%b expected 30/0/0", bus.Address, bus.instRead, bus.fetch_valid); end
    bus.call_en   = 1'b1;
    bus.br_target = 8'h77;
    bus.ret_en    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.Address !== 8'h30 || bus.instRead !== 1'b0) begin errors++; $display("FAIL halt_hold%0d: got %h/%b expected 30/0", i, bus.Address, bus.instRead); end
    end
    bus.call_en = 1'b0;
    bus.ret_en  = 1'b0;
    bus.halt    = 1'b0;
    bus.resume  = 1'b1;
    tick();
    bus.resume = 1'b0;
    checks++; if (bus.Address !== 8'h30 || bus.instRead !== 1'b1) begin errors++; $display("FAIL resume: got %h/%b expected 30/1", bus.Address, bus.instRead); end
    tick();
    checks++; if (bus.fetch_pc !== 8'h30 || bus.fetch_valid !== 1'b1 || bus.Address !== 8'h31) begin errors++; $display("FAIL resume_fetch: got %h/%b/%h expected 30/1/31", bus.fetch_pc, bus.fetch_valid, bus.Address); end
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    tick();
    checks++; if (bus.Address !== 8'h31 || bus.instRead !== 1'b0) begin errors++; $display("FAIL halt2: got %h/%b expected 31/0", bus.Address, bus.instRead); end
    jump(8'h60);
    checks++; if (bus.Address !== 8'h60 || bus.instRead !== 1'b1) begin errors++; $display("FAIL halt_br: got %h/%b expected 60/1", bus.Address, bus.instRead); end
    tick();
    checks++; if (bus.fetch_pc !== 8'h60 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL halt_br_fetch: got %h/%b expected 60/1", bus.fetch_pc, bus.fetch_valid); end
  endtask

`ifdef FETCH_RAS_EN
  task automatic test_ras();
    logic [7:0] ret_exp [5];
    test_reset();
    jump(8'h07);
    bus.call_en   = 1'b1;
    bus.br_target = 8'h50;
    tick();
    bus.call_en = 1'b0;
    checks++; if (bus.Address !== 8'h50 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL call: got %h/%b expected 50/0", bus.Address, bus.fetch_valid); end
    bus.ret_en = 1'b1;
    tick();
    checks++; if (bus.Address !== 8'h08 || bus.ras_err !== 1'b0) begin errors++; $display("FAIL ret: got %h/%b expected 08/0", bus.Address, bus.ras_err); end
    tick();
    bus.ret_en = 1'b0;
    checks++; if (bus.Address !== 8'h00 || bus.ras_err !== 1'b1) begin errors++; $display("FAIL ret_underflow: got %h/%b expected 00/1", bus.Address, bus.ras_err); end
    tick();
    checks++; if (bus.ras_err !== 1'b1 || bus.Address !== 8'h01) begin errors++; $display("FAIL raserr_sticky: got %b/%h expected 1/01", bus.ras_err, bus.Address); end
    test_reset();
    jump(8'h07);
    bus.call_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.br_target = 8'h50 + 8'(i * 16);
      tick();
      checks++; if (bus.Address !== 8'h50 + 8'(i * 16)) begin errors++; $display("FAIL call_chain%0d: got %h expected %h", i, bus.Address, 8'h50 + 8'(i * 16)); end
    end
    bus.call_en = 1'b0;
    ret_exp[0] = 8'h81; ret_exp[1] = 8'h71; ret_exp[2] = 8'h61; ret_exp[3] = 8'h51; ret_exp[4] = 8'h00;
    bus.ret_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.Address !== ret_exp[i] || bus.ras_err !== (i == 4)) begin errors++; $display("FAIL ret_chain%0d: got %h/%b expected %h/%b", i, bus.Address, bus.ras_err, ret_exp[i], (i == 4)); end
    end
    bus.ret_en = 1'b0;
  endtask
`else
  task automatic test_ras();
    test_reset();
    jump(8'h07);
    bus.call_en   = 1'b1;
    bus.br_target = 8'h50;
    tick();
    bus.call_en = 1'b0;
    checks++; if (bus.Address !== 8'h50 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL call_as_br: got %h/%b expected 50/0", bus.Address, bus.fetch_valid); end
    bus.ret_en = 1'b1;
    tick();
    checks++; if (bus.Address !== 8'h51 || bus.fetch_pc !== 8'h50 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL ret_ignored: got %h/%h/%b expected 51/50/1", bus.Address, bus.fetch_pc, bus.fetch_valid); end
    tick();
    bus.ret_en = 1'b0;
    checks++; if (bus.Address !== 8'h52 || bus.ras_err !== 1'b0) begin errors++; $display("FAIL ret_ignored2: got %h/%b expected 52/0", bus.Address, bus.ras_err); end
  endtask
`endif

  initial begin
    bus.stall     = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = 8'h00;
    bus.call_en   = 1'b0;
    bus.ret_en    = 1'b0;
    bus.halt      = 1'b0;
    bus.resume    = 1'b0;
    test_reset();
    test_branch();
    test_stall_branch();
    test_wrap();
    test_halt();
    test_ras();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
